// File: rtl/trdb_packet_arbiter_if.sv
// -----------------------------------------------------------------------------
// trdb_packet_arbiter_if
//
// Purpose:
//   Bundles the producer-side request bus and the word-stream output of the
//   trace packet arbiter so the arbiter and its environment share one port.
//
// Parameters (must match the arbiter instance):
//   NUM_REQ    number of packet producers
//   PACKET_LEN packet width in bits (multiple of WORD_LEN)
//   WORD_LEN   output word width
//   LEN_W      width of one length field
//   GID_W      width of the grant index
//
// Signals:
//   req_valid_i   [NUM_REQ]            per-producer packet valid
//   req_ready_o   [NUM_REQ]            per-producer accept, one-hot or zero
//   req_packet_i  [NUM_REQ*PACKET_LEN] packet bits, bit 0 transmitted first
//   req_len_i     [NUM_REQ*LEN_W]      packet length in bits
//   word_o        [WORD_LEN]           output word
//   word_valid_o                       output word valid
//   word_ready_i                       sink ready
//   word_last_o                        final word of a packet
//   grant_id_o    [GID_W]              producer currently being emitted
//   busy_o                             arbiter not idle
//
// Modports:
//   master  the arbiter itself (drives accepts and the word stream)
//   slave   producers plus word sink (drive requests and word_ready_i)
// -----------------------------------------------------------------------------
interface trdb_packet_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int PACKET_LEN = 128,
  parameter int WORD_LEN   = 32,
  parameter int LEN_W      = $clog2(PACKET_LEN) + 1,
  parameter int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*PACKET_LEN-1:0] req_packet_i;
  logic [NUM_REQ*LEN_W-1:0]      req_len_i;
  logic [WORD_LEN-1:0]           word_o;
  logic                          word_valid_o;
  logic                          word_ready_i;
  logic                          word_last_o;
  logic [GID_W-1:0]              grant_id_o;
  logic                          busy_o;

  modport master (
    input  req_valid_i,
    input  req_packet_i,
    input  req_len_i,
    input  word_ready_i,
    output req_ready_o,
    output word_o,
    output word_valid_o,
    output word_last_o,
    output grant_id_o,
    output busy_o
  );

  modport slave (
    output req_valid_i,
    output req_packet_i,
    output req_len_i,
    output word_ready_i,
    input  req_ready_o,
    input  word_o,
    input  word_valid_o,
    input  word_last_o,
    input  grant_id_o,
    input  busy_o
  );

endinterface

// File: rtl/trdb_packet_arbiter.sv
// -----------------------------------------------------------------------------
// trdb_packet_arbiter
//
// Purpose:
//   Shares the trace packet output path between several packet producers
//   (instruction-trace encoder, periodic sync generator, software packet
//   source). One pending packet is picked per round in round-robin order,
//   captured, and serialized LSB-first into WORD_LEN-bit words. Bits of the
//   last word beyond the packet length are forced to zero.
//
// Ports:
//   clk_i  clock, single domain
//   rst_i  synchronous active-high reset
//   bus    trdb_packet_arbiter_if.master: request bus (valid/ready/packet/len
//          per producer) and output word stream (word/valid/ready/last),
//          plus grant_id_o and busy_o status
//
// Optional feature:
//   TRDB_PACKET_ARB_HEADER_EN  when defined, every packet is preceded by one
//   header word {16'h0, 8'(grant_id), 8'(clamped length)}. A zero-length
//   packet then emits only that header, flagged as last.
//
// Timing notes:
//   req_ready_o is combinational from req_valid_i and the state only;
//   word_ready_i never reaches req_ready_o in the same cycle. All word-stream
//   outputs and status outputs come straight from registers.
// -----------------------------------------------------------------------------
module trdb_packet_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int PACKET_LEN = 128,
  parameter int WORD_LEN   = 32,
  parameter int LEN_W      = $clog2(PACKET_LEN) + 1,
  parameter int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  trdb_packet_arbiter_if.master   bus
);

  localparam int MAX_WORDS = PACKET_LEN / WORD_LEN;
  // Word counter must hold 0..MAX_WORDS inclusive.
  localparam int NW_W      = $clog2(MAX_WORDS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Word idx of the packet with every bit at or beyond len forced to zero.
  function automatic logic [WORD_LEN-1:0] slice_word(
    input logic [PACKET_LEN-1:0] pkt,
    input logic [LEN_W-1:0]      len,
    input logic [NW_W-1:0]       idx
  );
    logic [WORD_LEN-1:0] w;
    int                  base;
    w    = '0;
    base = int'(idx) * WORD_LEN;
    for (int b = 0; b < WORD_LEN; b++) begin
      if (((base + b) < int'(len)) && ((base + b) < PACKET_LEN)) begin
        w[b] = pkt[base + b];
      end else begin
        w[b] = 1'b0;
      end
    end
    return w;
  endfunction

`ifdef TRDB_PACKET_ARB_HEADER_EN
  // Header word layout: {16'h0, 8-bit grant id, 8-bit clamped length}.
  function automatic logic [WORD_LEN-1:0] hdr_word(
    input logic [GID_W-1:0] gid,
    input logic [LEN_W-1:0] len
  );
    logic [31:0] h;
    h = {16'h0000, 8'(gid), 8'(len)};
    return WORD_LEN'(h);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]            state_r;
  logic [PACKET_LEN-1:0] pkt_r;
  logic [LEN_W-1:0]      len_r;
  logic [NW_W-1:0]       nwords_r;
  logic [NW_W-1:0]       idx_r;
  logic [GID_W-1:0]      gid_r;
  logic [GID_W-1:0]      last_grant_r;
  logic [WORD_LEN-1:0]   word_r;
  logic                  valid_r;
  logic                  last_r;
  logic                  busy_r;

  logic [1:0]            state_nxt_s;
  logic [PACKET_LEN-1:0] pkt_nxt_s;
  logic [LEN_W-1:0]      len_nxt_s;
  logic [NW_W-1:0]       nwords_nxt_s;
  logic [NW_W-1:0]       idx_nxt_s;
  logic [GID_W-1:0]      gid_nxt_s;
  logic [GID_W-1:0]      last_grant_nxt_s;
  logic [WORD_LEN-1:0]   word_nxt_s;
  logic                  valid_nxt_s;
  logic                  last_nxt_s;
  logic                  busy_nxt_s;

  logic                  win_found_s;
  logic [GID_W-1:0]      win_id_s;
  logic [PACKET_LEN-1:0] win_pkt_s;
  logic [LEN_W-1:0]      win_len_raw_s;
  logic [LEN_W-1:0]      win_len_s;
  logic [NW_W-1:0]       win_nw_s;
  logic                  grant_ok_s;
  logic                  word_fire_s;
  logic [NUM_REQ-1:0]    req_ready_s;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------

  // Round-robin search starting one past the previous winner.
  always_comb begin : rr_search
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_id_s    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_grant_r) + i) % NUM_REQ;
      if (!win_found_s && bus.req_valid_i[cand]) begin
        win_found_s = 1'b1;
        win_id_s    = GID_W'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Winner's packet, clamped length and word count; accept only in IDLE.
  always_comb begin : win_capture
    win_pkt_s     = bus.req_packet_i[int'(win_id_s)*PACKET_LEN +: PACKET_LEN];
    win_len_raw_s = bus.req_len_i[int'(win_id_s)*LEN_W +: LEN_W];
    if (win_len_raw_s > LEN_W'(PACKET_LEN)) begin
      win_len_s = LEN_W'(PACKET_LEN);
    end else begin
      win_len_s = win_len_raw_s;
    end
    win_nw_s    = NW_W'((int'(win_len_s) + WORD_LEN - 1) / WORD_LEN);
    // A request seen during reset would be accepted and then lost.
    grant_ok_s  = (state_r == S_IDLE) && win_found_s && !rst_i;
    if (grant_ok_s) begin
      req_ready_s = NUM_REQ'(1) << win_id_s;
    end else begin
      req_ready_s = '0;
    end
    word_fire_s = valid_r && bus.word_ready_i;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------

  // Next-state and next-output computation for the IDLE/HDR/EMIT sequencer.
  always_comb begin : next_state
    state_nxt_s      = state_r;
    pkt_nxt_s        = pkt_r;
    len_nxt_s        = len_r;
    nwords_nxt_s     = nwords_r;
    idx_nxt_s        = idx_r;
    gid_nxt_s        = gid_r;
    last_grant_nxt_s = last_grant_r;
    word_nxt_s       = word_r;
    valid_nxt_s      = valid_r;
    last_nxt_s       = last_r;

    case (state_r)
      S_IDLE: begin
        if (grant_ok_s) begin
          pkt_nxt_s        = win_pkt_s;
          len_nxt_s        = win_len_s;
          nwords_nxt_s     = win_nw_s;
          gid_nxt_s        = win_id_s;
          last_grant_nxt_s = win_id_s;
          idx_nxt_s        = '0;
`ifdef TRDB_PACKET_ARB_HEADER_EN
          state_nxt_s      = S_HDR;
          word_nxt_s       = hdr_word(win_id_s, win_len_s);
          valid_nxt_s      = 1'b1;
          last_nxt_s       = (win_len_s == '0);
`else
          state_nxt_s      = S_EMIT;
          if (win_nw_s == '0) begin
            // Zero-length packet: one dead EMIT cycle, nothing presented.
            word_nxt_s  = '0;
            valid_nxt_s = 1'b0;
            last_nxt_s  = 1'b0;
          end else begin
            word_nxt_s  = slice_word(win_pkt_s, win_len_s, '0);
            valid_nxt_s = 1'b1;
            last_nxt_s  = (win_nw_s == NW_W'(1));
          end
`endif
        end else begin
          state_nxt_s = S_IDLE;
        end
      end

      S_HDR: begin
`ifdef TRDB_PACKET_ARB_HEADER_EN
        if (word_fire_s) begin
          if (nwords_r == '0) begin
            state_nxt_s = S_IDLE;
            word_nxt_s  = '0;
            valid_nxt_s = 1'b0;
            last_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = S_EMIT;
            idx_nxt_s   = '0;
            word_nxt_s  = slice_word(pkt_r, len_r, '0);
            valid_nxt_s = 1'b1;
            last_nxt_s  = (nwords_r == NW_W'(1));
          end
        end else begin
          state_nxt_s = S_HDR;
        end
`else
        state_nxt_s = S_IDLE;
        word_nxt_s  = '0;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
`endif
      end

      S_EMIT: begin
        if (nwords_r == '0) begin
          state_nxt_s = S_IDLE;
          word_nxt_s  = '0;
          valid_nxt_s = 1'b0;
          last_nxt_s  = 1'b0;
        end else if (word_fire_s) begin
          if (idx_r == (nwords_r - NW_W'(1))) begin
            state_nxt_s = S_IDLE;
            idx_nxt_s   = '0;
            word_nxt_s  = '0;
            valid_nxt_s = 1'b0;
            last_nxt_s  = 1'b0;
          end else begin
            idx_nxt_s   = idx_r + NW_W'(1);
            word_nxt_s  = slice_word(pkt_r, len_r, idx_r + NW_W'(1));
            valid_nxt_s = 1'b1;
            last_nxt_s  = ((idx_r + NW_W'(1)) == (nwords_r - NW_W'(1)));
          end
        end else begin
          // Stalled: word, last and grant id hold.
          state_nxt_s = S_EMIT;
        end
      end

      default: begin
        state_nxt_s = S_IDLE;
        idx_nxt_s   = '0;
        word_nxt_s  = '0;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
      end
    endcase

    busy_nxt_s = (state_nxt_s != S_IDLE);
  end

  // State and output registers; reset drops any packet in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= S_IDLE;
      pkt_r        <= '0;
      len_r        <= '0;
      nwords_r     <= '0;
      idx_r        <= '0;
      gid_r        <= '0;
      last_grant_r <= GID_W'(NUM_REQ - 1);
      word_r       <= '0;
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pkt_r        <= pkt_nxt_s;
      len_r        <= len_nxt_s;
      nwords_r     <= nwords_nxt_s;
      idx_r        <= idx_nxt_s;
      gid_r        <= gid_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      word_r       <= word_nxt_s;
      valid_r      <= valid_nxt_s;
      last_r       <= last_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign bus.req_ready_o  = req_ready_s;
  assign bus.word_o       = word_r;
  assign bus.word_valid_o = valid_r;
  assign bus.word_last_o  = last_r;
  assign bus.grant_id_o   = gid_r;
  assign bus.busy_o       = busy_r;

endmodule

// File: doc/trdb_packet_arbiter.md
# trdb_packet_arbiter

Sequencer that shares the trace packet output path between several packet producers: the instruction-trace encoder, the periodic sync generator and the software-triggered packet source. It picks one pending packet per round (round-robin), captures it, and serializes it into 32-bit words for the downstream word FIFO/APB readout. The unused bits of the last word are masked. It sits between the packet producers and the trace output buffer.

## Interface
- `NUM_REQ`, 3: number of packet producers (2..8).
- `PACKET_LEN`, 128: packet width in bits; a multiple of `WORD_LEN`.
- `WORD_LEN`, 32: output word width.
- `LEN_W`, $clog2(PACKET_LEN)+1 = 8: width of the length field.

Ports:
- `clk_i` in, 1: clock. One clock domain only.
- `rst_i` in, 1: reset. Synchronous and active-high.
- `req_valid_i` in, NUM_REQ: per-producer packet valid.
- `req_ready_o` out, NUM_REQ: per-producer accept. One-hot or zero.
- `req_packet_i` in, NUM_REQ×PACKET_LEN: packet bits. Bit 0 is the first transmitted bit.
- `req_len_i` in, NUM_REQ×LEN_W: packet length in bits.
- `word_o` out, WORD_LEN: output word.
- `word_valid_o` out, 1: output word valid.
- `word_ready_i` in, 1: sink ready.
- `word_last_o` out, 1: marks the final word of a packet.
- `grant_id_o` out, $clog2(NUM_REQ): index of the producer currently being emitted.
- `busy_o` out, 1: high when not in IDLE.

## Operation
- States: IDLE, HDR (only with the macro), EMIT.
- **IDLE:**
  - The arbiter searches `req_valid_i` round-robin, starting at `last_grant+1` and wrapping at NUM_REQ.
  - `req_ready_o[g]` is asserted combinationally for the winner `g` only.
  - On that cycle the block registers `req_packet_i[g]`, the clamped length and `g`, and sets `last_grant` to `g`.
  - Next state is HDR or EMIT. If no request is valid, it stays in IDLE and all `req_ready_o` are 0.
- **Length rules:**
  - `len_c = min(req_len_i, PACKET_LEN)`.
  - `nwords = ceil(len_c / WORD_LEN)`, computed at capture.
  - If `len_c == 0`, the packet is consumed and emits nothing. The FSM returns to IDLE on the next cycle, so the zero-length packet costs one dead cycle.
- **EMIT:**
  - `word_o` carries slice `idx` (bits `idx*WORD_LEN +: WORD_LEN`), starting at idx 0.
  - In the last word, bits at positions ≥ `len_c` are forced to 0.
  - `word_last_o` is high when `idx == nwords-1`.
  - On `word_valid_o && word_ready_i`, idx increments. After the last word is accepted, the FSM goes to IDLE.
- **Output stability:** while `word_valid_o` is high and `word_ready_i` is low, `word_o`, `word_last_o` and `grant_id_o` hold stable.
- **Request inputs:** requests are not sampled outside IDLE. Producers must hold valid and data until ready (standard valid/ready). Changes to a non-granted producer's inputs are ignored.
- **Reset values (all outputs):**
  - `req_ready_o`, `word_o`, `word_valid_o`, `word_last_o`, `grant_id_o`, `busy_o` = 0.
  - Internally, state = IDLE, idx = 0, `last_grant = NUM_REQ-1`, so producer 0 wins first.
- **Reset mid-packet:** the packet in flight is discarded and no further words are emitted. The producer is not re-requested, since it was already accepted.

## Timing
- Accept at cycle N, first word valid at N+1 (N+2 with the header).
- Back-to-back words are emitted at one per cycle when `word_ready_i` is held high.
- Full-rate cost per packet: `nwords+1` cycles, or `nwords+2` with the header. The IDLE cycle is the arbitration and capture cycle.
- `req_ready_o` is combinational from `req_valid_i` and the state. There is no combinational path from `word_ready_i` to any `req_ready_o`.
- `word_valid_o` and `word_o` are registered-state driven.
- `word_valid_o` never depends combinationally on `word_ready_i`.

## Configuration
- **Macro `TRDB_PACKET_ARB_HEADER_EN`:**
  - When defined, HDR is entered after capture.
  - It emits one header word `{16'h0, 8'(grant_id), 8'(len_c)}` with `word_last_o = 0`, then enters EMIT.
  - A zero-length packet emits only the header, with `word_last_o = 1`, then goes to IDLE.
- **Without the macro:** HDR does not exist and the output stream is payload only.

## Test plan
- **Single producer:** producer 0, len=70, packet=128'h...DDDDCCCC_BBBBBBBB_AAAAAAAA, sink always ready. Expect 3 words: AAAAAAAA, BBBBBBBB, then the third word carrying bits 64–69 of the packet with bits ≥6 zeroed. `word_last_o` is high on the 3rd word only. `req_ready_o[0]` pulses exactly once.
- **Round-robin fairness:** all 3 producers valid continuously with len=32. Expect grant order 0,1,2,0,1,2 and 2 cycles per packet.
- **Backpressure:** len=128, `word_ready_i` toggling 1,0,0,1,… Expect 4 words in order, each held stable while stalled, and no `req_ready_o` until the 4th word is accepted.
- **Length boundaries:**
  - len=0: producer accepted, zero words, IDLE after 1 cycle.
  - len=200: clamped to 128, emits 4 words.
  - len=32: 1 word with `word_last_o` = 1.
- **Mid-packet reset:** `rst_i` asserted for 1 cycle during word 2 of 4. Expect all outputs 0 on the next cycle, no further words, and producer 0 winning first after reset.
- **Header (with `TRDB_PACKET_ARB_HEADER_EN`):** producer 2, len=40. Expect header 32'h0000_0228, then 2 payload words, with `word_last_o` on the final one.
